// File: rtl/buffer_reduce_pkg.sv
// Shared definitions for the buffer reduction engine: operator encodings,
// FSM state encoding and the per-operator accumulator identity values.
package buffer_reduce_pkg;

    localparam logic [1:0] MODE_SUM = 2'd0;
    localparam logic [1:0] MODE_MIN = 2'd1;
    localparam logic [1:0] MODE_MAX = 2'd2;
    localparam logic [1:0] MODE_XOR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_STORE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Identities are built at a fixed wide width and truncated by the caller,
    // so one function serves every data width up to IDENT_W.
    localparam int IDENT_W = 64;

    // Operator identity: 0 for sum/xor, largest signed value for min,
    // smallest signed value for max, all expressed for a dataW-bit word.
    function automatic logic [IDENT_W-1:0] identityValue(input logic [1:0] mode,
                                                         input int dataW);
        logic [IDENT_W-1:0] signBit;
        signBit = IDENT_W'(1) << (dataW - 1);
        case (mode)
            MODE_MIN: identityValue = signBit - IDENT_W'(1);
            MODE_MAX: identityValue = ~(signBit - IDENT_W'(1));
            default:  identityValue = '0;
        endcase
    endfunction

endpackage

// File: rtl/buffer_reduce_alu.sv
// Combinational fold operator: combines the running accumulator with one
// element according to the selected mode. Kept standalone so that a
// multi-lane engine can instantiate several copies.
module reduce_alu
    import buffer_reduce_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] acc_i,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] result_o
);

    // Select the operator; min/max keep the accumulator on a tie.
    always_comb begin
        result_o = acc_i;
        case (mode_i)
            MODE_SUM: result_o = acc_i + data_i;
            MODE_MIN: result_o = ($signed(data_i) < $signed(acc_i)) ? data_i : acc_i;
            MODE_MAX: result_o = ($signed(data_i) > $signed(acc_i)) ? data_i : acc_i;
            MODE_XOR: result_o = acc_i ^ data_i;
            default:  result_o = acc_i;
        endcase
    end

endmodule

// File: rtl/buffer_reduce.sv
// Memory-mapped reduction engine: walks a strided word buffer through a
// data-memory master port, folds each element into an accumulator and
// stores the final value to a destination address.
module buffer_reduce
    import buffer_reduce_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic [ADDR_W-1:0] stride,
    input  logic [1:0]        mode,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [31:0]       cycles,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [ADDR_W-1:0]   stride_q, stride_d;
    logic [LEN_W-1:0]    remain_q, remain_d;
    logic [1:0]          mode_q, mode_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [31:0]         count_q, count_d;
    logic [31:0]         cycles_q, cycles_d;

    logic                startAccept;
    logic                loadAccept;
    logic                storeAccept;
    logic                running;
    logic [DATA_W-1:0]   aluOut;
    logic [IDENT_W-1:0]  identWide;
    logic [DATA_W-1:0]   accInit;

    assign startAccept = (state_q == ST_IDLE) && start;
    assign loadAccept  = (state_q == ST_READ) && mem_ready;
    assign storeAccept = (state_q == ST_STORE) && mem_ready;
    assign running     = (state_q == ST_READ) || (state_q == ST_STORE);

    // The identity follows the mode presented with start, not the latched one.
    assign identWide = identityValue(mode, DATA_W);
    assign accInit   = identWide[DATA_W-1:0];

    reduce_alu #(.DATA_W(DATA_W)) u_alu (
        .acc_i    (acc_q),
        .mode_i   (mode_q),
        .data_i   (mem_rdata),
        .result_o (aluOut)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: skip READ for an empty buffer, leave READ on the last element.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (length != '0) ? ST_READ : ST_STORE;
                end
            end
            ST_READ: begin
                if (mem_ready && (remain_q == LEN_W'(1))) begin
                    state_d = ST_STORE;
                end
            end
            ST_STORE: begin
                if (mem_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: the request is decoded from registered state only, so it
    // stays stable for as long as the memory holds off mem_ready.
    always_comb begin
        busy      = running;
        done      = (state_q == ST_DONE);
        mem_req   = running;
        mem_we    = (state_q == ST_STORE);
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == ST_READ) begin
            mem_addr = ptr_q;
        end else if (state_q == ST_STORE) begin
            mem_addr  = dst_q;
            mem_wdata = acc_q;
        end
    end

    // Datapath next state: latch the job on start, fold and advance on each
    // accepted load, count busy cycles with saturation, publish on completion.
    always_comb begin
        ptr_d    = ptr_q;
        dst_d    = dst_q;
        stride_d = stride_q;
        remain_d = remain_q;
        mode_d   = mode_q;
        acc_d    = acc_q;
        result_d = result_q;
        count_d  = count_q;
        cycles_d = cycles_q;
        if (startAccept) begin
            ptr_d    = base_addr;
            dst_d    = dst_addr;
            stride_d = stride;
            remain_d = length;
            mode_d   = mode;
            acc_d    = accInit;
            count_d  = '0;
        end
        if (loadAccept) begin
            acc_d    = aluOut;
            ptr_d    = ptr_q + stride_q;
            remain_d = remain_q - LEN_W'(1);
        end
        if (running && (count_q != '1)) begin
            count_d = count_q + 32'd1;
        end
        if (storeAccept) begin
            result_d = acc_q;
        end
        if (state_q == ST_DONE) begin
            cycles_d = count_q;
        end
    end

    // Datapath registers; reset clears the reported result and cycle count too.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q    <= '0;
            dst_q    <= '0;
            stride_q <= '0;
            remain_q <= '0;
            mode_q   <= MODE_SUM;
            acc_q    <= '0;
            result_q <= '0;
            count_q  <= '0;
            cycles_q <= '0;
        end else begin
            ptr_q    <= ptr_d;
            dst_q    <= dst_d;
            stride_q <= stride_d;
            remain_q <= remain_d;
            mode_q   <= mode_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            count_q  <= count_d;
            cycles_q <= cycles_d;
        end
    end

    assign result = result_q;
    assign cycles = cycles_q;

endmodule

// File: tb/tb_buffer_reduce.sv
// Directed bench for buffer_reduce: a table of reduction jobs over a
// preloaded word memory, plus hand-written reset and idle sequences.
module tb_buffer_reduce;

    localparam int BUDGET = 2000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] base_addr;
    logic [31:0] dst_addr;
    logic [15:0] length;
    logic [31:0] stride;
    logic [1:0]  mode;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] cycles;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:1023];

    int nApplied    = 0;
    int nMiscompare = 0;

    typedef struct {
        string       name;
        logic [31:0] base;
        logic [31:0] dst;
        logic [15:0] len;
        logic [31:0] stride;
        logic [1:0]  mode;
        bit          randReady;
        int          startAt;
        logic [31:0] expResult;
    } vec_t;

    vec_t vecs[$];

    buffer_reduce dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .dst_addr  (dst_addr),
        .length    (length),
        .stride    (stride),
        .mode      (mode),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .cycles    (cycles),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Word memory responds combinationally to the current load address.
    assign mem_rdata = mem[mem_addr[11:2]];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nApplied++;
        if (actual !== expected) begin
            nMiscompare++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic addVec(input string name, input logic [31:0] base, input logic [31:0] dst,
                          input logic [15:0] len, input logic [31:0] str, input logic [1:0] md,
                          input bit rr, input int startAt, input logic [31:0] expResult);
        vec_t v;
        v.name = name; v.base = base; v.dst = dst; v.len = len; v.stride = str;
        v.mode = md; v.randReady = rr; v.startAt = startAt; v.expResult = expResult;
        vecs.push_back(v);
    endtask

    // Launch one job at a negedge so start is sampled at the next rising edge.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        base_addr = v.base;
        dst_addr  = v.dst;
        length    = v.len;
        stride    = v.stride;
        mode      = v.mode;
        mem_ready = 1'b1;
        start     = 1'b1;
    endtask

    // Run one job cycle by cycle, checking every accepted load address,
    // the single store, the done timing and the reported counters.
    task automatic runVector(input vec_t v);
        logic [31:0] expAddr;
        logic [31:0] stAddr;
        logic [31:0] stData;
        int loads, stores, dones, stalls, doneCyc, strideErr, extraBusy;
        bit seenDone;
        expAddr = v.base; stAddr = '0; stData = '0;
        loads = 0; stores = 0; dones = 0; stalls = 0; doneCyc = 0;
        strideErr = 0; extraBusy = 0; seenDone = 0;
        applyStimulus(v);
        for (int cyc = 1; cyc <= BUDGET && !seenDone; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == v.startAt) begin
                start     = 1'b1;
                base_addr = 32'h0;
                dst_addr  = 32'h600;
                length    = 16'd3;
                stride    = 32'd4;
                mode      = 2'd0;
            end
            mem_ready = v.randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cyc == 1) checkOutput({v.name, "_busy_rise"}, 32'(busy), 32'd1);
            if (mem_req && !mem_we) begin
                if (mem_ready) begin
                    if (mem_addr !== expAddr) strideErr++;
                    expAddr = expAddr + v.stride;
                    loads++;
                end else begin
                    stalls++;
                end
            end
            if (mem_req && mem_we) begin
                if (mem_ready) begin
                    stores++;
                    stAddr = mem_addr;
                    stData = mem_wdata;
                end else begin
                    stalls++;
                end
            end
            if (done) begin
                seenDone = 1;
                doneCyc  = cyc;
                dones++;
            end
        end
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (done) dones++;
            if (busy) extraBusy++;
        end
        checkOutput({v.name, "_done_seen"}, 32'(seenDone), 32'd1);
        checkOutput({v.name, "_result"}, result, v.expResult);
        checkOutput({v.name, "_store_data"}, stData, v.expResult);
        checkOutput({v.name, "_store_addr"}, stAddr, v.dst);
        checkOutput({v.name, "_store_count"}, 32'(stores), 32'd1);
        checkOutput({v.name, "_done_count"}, 32'(dones), 32'd1);
        checkOutput({v.name, "_idle_after"}, 32'(extraBusy), 32'd0);
        checkOutput({v.name, "_load_count"}, 32'(loads), 32'(v.len));
        checkOutput({v.name, "_addr_errors"}, 32'(strideErr), 32'd0);
        checkOutput({v.name, "_cycles"}, cycles, 32'(v.len) + 32'd1 + 32'(stalls));
        checkOutput({v.name, "_done_cycle"}, 32'(doneCyc), 32'(v.len) + 32'd2 + 32'(stalls));
    endtask

    // Abort a job while it is reading and confirm everything drops at once.
    task automatic resetMidRun();
        vec_t v;
        int stores;
        stores = 0;
        v.name = "rst"; v.base = 32'h100; v.dst = 32'h700; v.len = 16'd20;
        v.stride = 32'd4; v.mode = 2'd0; v.randReady = 0; v.startAt = 0; v.expResult = '0;
        applyStimulus(v);
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (mem_req && mem_we) stores++;
        end
        checkOutput("rst_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_cycles", cycles, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            if (mem_req || done) stores++;
        end
        checkOutput("rst_no_store", 32'(stores), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; dst_addr = '0; length = '0;
        stride = '0; mode = '0; mem_ready = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        for (int i = 0; i < 128; i++) mem[64 + i] = 32'(i);
        mem[256] = 32'd5;
        mem[257] = 32'hFFFF_FFFD;
        mem[258] = 32'h7FFF_FFFF;
        mem[259] = 32'hFFFF_FFFD;
        mem[260] = 32'd9;
        mem[288] = 32'hFFFF_FFFF;
        mem[289] = 32'd2;

        addVec("sum128",   32'h100, 32'h300, 16'd128, 32'd4,         2'd0, 0, 0, 32'd8128);
        addVec("min5",     32'h400, 32'h500, 16'd5,   32'd4,         2'd1, 0, 0, 32'hFFFF_FFFD);
        addVec("max5",     32'h400, 32'h504, 16'd5,   32'd4,         2'd2, 0, 0, 32'h7FFF_FFFF);
        addVec("xor5",     32'h400, 32'h508, 16'd5,   32'd4,         2'd3, 0, 0, 32'h7FFF_FFF3);
        addVec("stride8",  32'h100, 32'h50C, 16'd64,  32'd8,         2'd0, 1, 0, 32'd4032);
        addVec("len0min",  32'h100, 32'h510, 16'd0,   32'd4,         2'd1, 0, 0, 32'h7FFF_FFFF);
        addVec("negstr",   32'h124, 32'h514, 16'd10,  32'hFFFF_FFFC, 2'd0, 0, 0, 32'd45);
        addVec("overflow", 32'h480, 32'h518, 16'd2,   32'd4,         2'd0, 0, 0, 32'd1);
        addVec("startbusy",32'h400, 32'h51C, 16'd5,   32'd4,         2'd2, 0, 3, 32'h7FFF_FFFF);

        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_result", result, 32'd0);
        checkOutput("reset_cycles", cycles, 32'd0);
        checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
        checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
        checkOutput("reset_mem_addr", mem_addr, 32'd0);
        checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) runVector(vecs[i]);

        resetMidRun();
        runVector(vecs[1]);

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompare);
        $finish;
    end

endmodule
